serial_mag_comp: RTL and testbench

//   Bit-serial magnitude comparator. Works in the opposite direction to the

---
 rtl/serial_mag_comp_if.sv | 31 +++
 rtl/serial_mag_comp.sv | 137 +++++++++++++
 tb/tb_serial_mag_comp.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/serial_mag_comp_if.sv
// ============================================================================
// Module   : serial_mag_comp_if
// Brief    : Start/operand/result bundle for the bit-serial magnitude comparator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_mag_comp_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic             lt;
    logic             gt;
    logic             eq;

    modport master (
        output start, A, B,
        input  busy, done, lt, gt, eq
    );

    modport slave (
        input  start, A, B,
        output busy, done, lt, gt, eq
    );
endinterface

`default_nettype wire

// File: rtl/serial_mag_comp.sv
// ============================================================================
// Module   : serial_mag_comp
// Brief    : LSB-first bit-serial magnitude comparator, one bit pair per clock.
//            Define SERIAL_COMP_SIGNED_EN for two's-complement operands.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_mag_comp #(
    parameter int WIDTH = 8
) (
    input  wire logic           clk,
    input  wire logic           rst,
    serial_mag_comp_if.slave    bus
);

    localparam int               CNT_W  = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_accept;

    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [CNT_W-1:0] r_cnt;
    logic             r_lt;
    logic             r_gt;
    logic             r_eq;

    logic             w_last;
    logic             w_invert;
    logic             w_a_wins;
    logic             w_b_wins;
    logic             w_set_gt;
    logic             w_set_lt;
    logic             w_gt_nxt;
    logic             w_lt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // start is only honoured when no comparison is in flight
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_SHIFT;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_last = (r_cnt == C_LAST);

`ifdef SERIAL_COMP_SIGNED_EN
    // the sign bit carries negative weight, so its verdict is reversed
    assign w_invert = w_last;
`else
    assign w_invert = 1'b0;
`endif

    assign w_a_wins = r_sa[0] & ~r_sb[0];
    assign w_b_wins = ~r_sa[0] & r_sb[0];
    assign w_set_gt = w_invert ? w_b_wins : w_a_wins;
    assign w_set_lt = w_invert ? w_a_wins : w_b_wins;
    // a differing bit overrides whatever the less significant bits decided
    assign w_gt_nxt = w_set_gt | (r_gt & ~w_set_lt);
    assign w_lt_nxt = w_set_lt | (r_lt & ~w_set_gt);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sa  <= '0;
            r_sb  <= '0;
            r_cnt <= '0;
            r_lt  <= 1'b0;
            r_gt  <= 1'b0;
            r_eq  <= 1'b0;
        end else if (w_accept) begin
            r_sa  <= bus.A;
            r_sb  <= bus.B;
            r_cnt <= '0;
            r_lt  <= 1'b0;
            r_gt  <= 1'b0;
            r_eq  <= 1'b0;
        end else if (r_state == S_SHIFT) begin
            r_sa <= {1'b0, r_sa[WIDTH-1:1]};
            r_sb <= {1'b0, r_sb[WIDTH-1:1]};
            r_lt <= w_lt_nxt;
            r_gt <= w_gt_nxt;
            if (w_last) begin
                r_eq <= ~(w_lt_nxt | w_gt_nxt);
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign bus.busy = (r_state == S_SHIFT);
    assign bus.done = (r_state == S_DONE);
    assign bus.lt   = r_lt;
    assign bus.gt   = r_gt;
    assign bus.eq   = r_eq;

endmodule

`default_nettype wire

// File: tb/tb_serial_mag_comp.sv
// ============================================================================
// Module   : tb_serial_mag_comp
// Brief    : Scoreboard bench for serial_mag_comp (WIDTH=8), random + directed.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_mag_comp;

    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    serial_mag_comp_if #(.WIDTH(WIDTH)) bus ();

    serial_mag_comp #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    logic [2:0] exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // expected {lt,gt,eq} straight from the numeric values
    function automatic logic [2:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef SERIAL_COMP_SIGNED_EN
        if ($signed(a) < $signed(b)) return 3'b100;
        if ($signed(a) > $signed(b)) return 3'b010;
`else
        if (a < b) return 3'b100;
        if (a > b) return 3'b010;
`endif
        return 3'b001;
    endfunction

    // monitor: every done pulse consumes one expected result
    initial begin : monitor
        logic       prev_done;
        logic [2:0] e;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && bus.done) begin
                chk("done_not_consecutive", int'(prev_done), 0);
                chk("busy_low_in_done", int'(bus.busy), 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("result_ltgteq", int'({bus.lt, bus.gt, bus.eq}), int'(e));
                end
            end
            prev_done = bus.done;
        end
    end

    // issue one accepted operation from IDLE and check its latency
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int k;
        int nb;
        bit found;
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        @(posedge clk); #1;
        exp_q.push_back(model(a, b));
        bus.start = 1'b0;
        bus.A     = WIDTH'($urandom);
        bus.B     = WIDTH'($urandom);
        k = 0; nb = 0; found = 1'b0;
        while (!found && k < 20) begin
            @(negedge clk);
            k++;
            if (bus.busy) nb++;
            if (bus.done) found = 1'b1;
        end
        chk("done_latency", k, 9);
        chk("busy_cycles", nb, 8);
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int k;
        bit seen;
        logic [2:0] held;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;

        // 1. reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({bus.busy, bus.done, bus.lt, bus.gt, bus.eq}), 0);
        @(posedge clk); #1;

        // 2. basic gt and result hold
        run_op(8'h5A, 8'h3C);
        held = model(8'h5A, 8'h3C);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done || {bus.lt, bus.gt, bus.eq} != held) seen = 1'b1;
        end
        chk("result_held_20", int'(seen), 0);
        chk("held_value", int'({bus.lt, bus.gt, bus.eq}), int'(held));
        @(posedge clk); #1;

        // 3. eq, then back-to-back lt with start held through DONE
        bus.start = 1'b1; bus.A = 8'h81; bus.B = 8'h81;
        @(posedge clk); #1;
        exp_q.push_back(model(8'h81, 8'h81));
        k = 0;
        do begin @(negedge clk); k++; end while (!bus.done && k < 20);
        chk("b2b_first_latency", k, 9);
        bus.A = 8'h00; bus.B = 8'hFF;
        exp_q.push_back(model(8'h00, 8'hFF));
        @(posedge clk); #1;
        bus.start = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (!bus.done && k < 20);
        chk("b2b_second_latency", k, 9);
        @(posedge clk); #1;

        // 4. start during SHIFT is ignored
        bus.start = 1'b1; bus.A = 8'h10; bus.B = 8'h01;
        @(posedge clk); #1;
        exp_q.push_back(model(8'h10, 8'h01));
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1 bus.start = 1'b1; bus.A = 8'h00;
        @(posedge clk); #1 bus.start = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (!bus.done && k < 20);
        chk("ignored_start_latency", k, 6);
        @(posedge clk); #1;

        // 5. reset mid-SHIFT aborts without a done pulse
        bus.start = 1'b1; bus.A = 8'hC3; bus.B = 8'h3C;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_outputs", int'({bus.busy, bus.done, bus.lt, bus.gt, bus.eq}), 0);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        chk("abort_no_done", int'(seen), 0);
        @(posedge clk); #1;
        run_op(8'h22, 8'h23);

        // 6. sign-bit cases
        run_op(8'h80, 8'h01);
        run_op(8'hFF, 8'hFE);
        run_op(8'h7F, 8'h80);

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            ra = WIDTH'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : WIDTH'($urandom);
            run_op(ra, rb);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        repeat (4) @(posedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
